// File: rtl/uart_mmio_bridge_pkg.sv
// uart_mmio_bridge_pkg: register offsets and STATUS bit positions
// shared by the UART MMIO bridge and its FIFOs.
package uart_mmio_bridge_pkg;

  localparam logic [7:0] REG_DATA   = 8'h00;
  localparam logic [7:0] REG_STATUS = 8'h40;
  localparam logic [7:0] REG_LEVEL  = 8'h80;
  localparam logic [7:0] REG_CTRL   = 8'hC0;

  localparam int ST_RX_NE    = 0;
  localparam int ST_TX_NF    = 1;
  localparam int ST_TX_NZ    = 2;
  localparam int ST_TX_EMPTY = 3;
  localparam int ST_RX_FULL  = 4;

  function automatic logic [31:0] level_word(
    input logic [7:0] rx_lvl,
    input logic [7:0] tx_lvl
  );
    return {8'h00, rx_lvl, 8'h00, tx_lvl};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with flush; push ignored when full,
// pop ignored when empty. Ports: push/wdata, pop/rdata, full/empty/count.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];

  // full is sampled before any same-cycle pop, so a pop
  // never opens room for a push in the same cycle
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      count_d = count_q + CW'(1);
      else if (do_pop && !do_push) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_mmio_bridge.sv
// uart_mmio_bridge: picorv32 native-bus window onto TX/RX byte FIFOs
// feeding an AXI-stream UART. Ports: mem_* bus, sel, tx_* / rx_* streams.
module uart_mmio_bridge
  import uart_mmio_bridge_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h2000_0000,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        sel,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic [7:0]  tx_tdata,
  output logic        tx_tvalid,
  input  logic        tx_tready,
  input  logic [7:0]  rx_tdata,
  input  logic        rx_tvalid,
  output logic        rx_tready
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic          pending, wr;
  logic [7:0]    off;
  logic          accept, flush;
  logic          tx_push, tx_pop, tx_full, tx_empty;
  logic          rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0]    tx_head, rx_head;
  logic [CW-1:0] tx_count, rx_count;
  logic [31:0]   status;
  logic          mem_ready_q, mem_ready_d;
  logic [31:0]   mem_rdata_q, mem_rdata_d;
  logic          unused_wdata;

  assign unused_wdata = ^mem_wdata[31:8];

  assign sel     = mem_valid && (mem_addr[31:8] == BASE_ADDR[31:8]);
  // ready_q blocks re-acceptance of the access just completed
  assign pending = sel && !mem_ready_q;
  assign wr      = |mem_wstrb;
  assign off     = mem_addr[7:0];

  assign tx_tvalid = !tx_empty;
  assign tx_tdata  = tx_empty ? 8'h00 : tx_head;
  assign tx_pop    = tx_tvalid && tx_tready;

  assign rx_tready = resetn && !rx_full;
  assign rx_push   = rx_tvalid && rx_tready;

  assign mem_ready = mem_ready_q;
  assign mem_rdata = mem_rdata_q;

  always_comb begin
    status              = '0;
    status[ST_RX_NE]    = !rx_empty;
    status[ST_TX_NF]    = !tx_full;
    status[ST_TX_NZ]    = (tx_count != '0);
    status[ST_TX_EMPTY] = tx_empty;
    status[ST_RX_FULL]  = rx_full;
  end

  always_comb begin
    accept      = 1'b0;
    flush       = 1'b0;
    tx_push     = 1'b0;
    rx_pop      = 1'b0;
    mem_rdata_d = '0;
    if (pending) begin
      unique case (1'b1)
        (off == REG_DATA): begin
          if (wr) begin
            // a write to a full TX FIFO stalls until room frees
            accept  = !tx_full;
            tx_push = !tx_full;
          end else begin
            accept = 1'b1;
            rx_pop = !rx_empty;
            if (!rx_empty)
              mem_rdata_d = {1'b1, 23'b0, rx_head};
          end
        end
        (off == REG_STATUS): begin
          accept = 1'b1;
          if (!wr) mem_rdata_d = status;
        end
        (off == REG_LEVEL): begin
          accept = 1'b1;
          if (!wr)
            mem_rdata_d = level_word(8'(rx_count), 8'(tx_count));
        end
        (off == REG_CTRL): begin
          accept = 1'b1;
          flush  = wr && mem_wdata[0];
        end
        default: accept = 1'b1;
      endcase
    end
    mem_ready_d = accept;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_ready_q <= 1'b0;
      mem_rdata_q <= '0;
    end else begin
      mem_ready_q <= mem_ready_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk    (clk),
    .resetn (resetn),
    .flush  (flush),
    .push   (tx_push),
    .wdata  (mem_wdata[7:0]),
    .pop    (tx_pop),
    .rdata  (tx_head),
    .full   (tx_full),
    .empty  (tx_empty),
    .count  (tx_count)
  );

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk    (clk),
    .resetn (resetn),
    .flush  (flush),
    .push   (rx_push),
    .wdata  (rx_tdata),
    .pop    (rx_pop),
    .rdata  (rx_head),
    .full   (rx_full),
    .empty  (rx_empty),
    .count  (rx_count)
  );

endmodule

// File: tb/tb_uart_mmio_bridge.sv
// tb_uart_mmio_bridge: directed and random traffic against a
// queue-based model of the UART MMIO bridge.
module tb_uart_mmio_bridge;

  localparam logic [31:0] BASE = 32'h2000_0000;
  localparam int D = 16;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_wstrb = '0;
  logic        tx_tready = 1'b0;
  logic        rx_tvalid = 1'b0;
  logic [7:0]  rx_tdata = '0;
  logic        sel, mem_ready, tx_tvalid, rx_tready;
  logic [31:0] mem_rdata;
  logic [7:0]  tx_tdata;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  txq[$];
  logic [7:0]  rxq[$];
  logic        m_rdy = 1'b0;
  logic [31:0] m_rdata = '0;
  bit          rx_acc = 1'b0;

  uart_mmio_bridge #(
    .BASE_ADDR  (BASE),
    .FIFO_DEPTH (D)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .mem_valid (mem_valid),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .sel       (sel),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .tx_tdata  (tx_tdata),
    .tx_tvalid (tx_tvalid),
    .tx_tready (tx_tready),
    .rx_tdata  (rx_tdata),
    .rx_tvalid (rx_tvalid),
    .rx_tready (rx_tready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_status();
    return {27'b0, rxq.size() == D, txq.size() == 0,
            txq.size() != 0, txq.size() != D, rxq.size() != 0};
  endfunction

  function automatic logic [31:0] m_level();
    return {8'h0, 8'(rxq.size()), 8'h0, 8'(txq.size())};
  endfunction

  // one clock: inputs already driven; model advanced; outputs checked
  task automatic step();
    logic [7:0]  off;
    logic [31:0] rd;
    bit wr, pend, acc, fl, txp, rxp, cpush, cpop, hit;
    #1;
    hit = mem_valid && (mem_addr[31:8] == BASE[31:8]);
    chk("sel", {31'b0, sel}, {31'b0, hit});
    pend  = hit && !m_rdy;
    wr    = (mem_wstrb != 0);
    off   = mem_addr[7:0];
    acc   = 0; fl = 0; cpush = 0; cpop = 0; rd = '0;
    txp   = (txq.size() != 0) && tx_tready;
    rxp   = rx_tvalid && (rxq.size() != D);
    if (pend) begin
      case (off)
        8'h00: begin
          if (wr) begin
            if (txq.size() < D) begin acc = 1; cpush = 1; end
          end else begin
            acc = 1;
            if (rxq.size() != 0) begin
              cpop = 1;
              rd = 32'h8000_0000 | 32'(rxq[0]);
            end
          end
        end
        8'h40: begin acc = 1; if (!wr) rd = m_status(); end
        8'h80: begin acc = 1; if (!wr) rd = m_level(); end
        8'hC0: begin acc = 1; fl = wr && mem_wdata[0]; end
        default: acc = 1;
      endcase
    end
    rx_acc = rxp;
    @(posedge clk);
    if (fl) begin
      txq.delete();
      rxq.delete();
    end else begin
      if (txp)   void'(txq.pop_front());
      if (cpush) txq.push_back(mem_wdata[7:0]);
      if (cpop)  void'(rxq.pop_front());
      if (rxp)   rxq.push_back(rx_tdata);
    end
    m_rdy   = acc;
    m_rdata = rd;
    @(negedge clk);
    chk("mem_ready", {31'b0, mem_ready}, {31'b0, m_rdy});
    chk("mem_rdata", mem_rdata, m_rdata);
    chk("tx_tvalid", {31'b0, tx_tvalid}, {31'b0, txq.size() != 0});
    if (txq.size() != 0) chk("tx_tdata", {24'b0, tx_tdata}, {24'b0, txq[0]});
    chk("rx_tready", {31'b0, rx_tready}, {31'b0, rxq.size() != D});
  endtask

  task automatic do_reset();
    resetn    = 1'b0;
    mem_valid = 1'b0;
    mem_wstrb = '0;
    rx_tvalid = 1'b0;
    tx_tready = 1'b0;
    txq.delete();
    rxq.delete();
    m_rdy   = 1'b0;
    m_rdata = '0;
    #1;
    chk("rst_ready", {31'b0, mem_ready}, 32'h0);
    chk("rst_rdata", mem_rdata, 32'h0);
    chk("rst_tvalid", {31'b0, tx_tvalid}, 32'h0);
    chk("rst_tdata", {24'b0, tx_tdata}, 32'h0);
    chk("rst_rx_tready", {31'b0, rx_tready}, 32'h0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  // one CPU access held until mem_ready, then one idle cycle
  task automatic cpu(input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] ws, output logic [31:0] rd,
                     output int n);
    mem_valid = 1'b1;
    mem_addr  = a;
    mem_wdata = wd;
    mem_wstrb = ws;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      n++;
      if (mem_ready) break;
    end
    chk("cpu_done", {31'b0, mem_ready}, 32'h1);
    rd = mem_rdata;
    mem_valid = 1'b0;
    mem_wstrb = '0;
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    int n, k;
    @(negedge clk);
    #2;
    do_reset();

    cpu(BASE + 32'h40, 32'h0, 4'h0, r, n);
    chk("status_reset", r, 32'h0000_000A);
    chk("tvalid_idle", {31'b0, tx_tvalid}, 32'h0);
    chk("rx_tready_idle", {31'b0, rx_tready}, 32'h1);

    cpu(BASE, 32'hFFFF_FF41, 4'hF, r, n);
    chk("wr_latency", n, 1);
    chk("tx_tvalid_1", {31'b0, tx_tvalid}, 32'h1);
    chk("tx_tdata_1", {24'b0, tx_tdata}, 32'h41);
    cpu(BASE + 32'h80, 32'h0, 4'h0, r, n);
    chk("level_1", r, 32'h0000_0001);

    for (int i = 1; i < 16; i++)
      cpu(BASE, 32'h41 + i, 4'h1, r, n);
    mem_valid = 1'b1;
    mem_addr  = BASE;
    mem_wdata = 32'h99;
    mem_wstrb = 4'h1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("stall", {31'b0, mem_ready}, 32'h0);
    end
    tx_tready = 1'b1;
    step();
    chk("stall_pop", {31'b0, mem_ready}, 32'h0);
    tx_tready = 1'b0;
    step();
    chk("unstall", {31'b0, mem_ready}, 32'h1);
    mem_valid = 1'b0;
    mem_wstrb = '0;
    step();
    cpu(BASE + 32'h80, 32'h0, 4'h0, r, n);
    chk("level_full", r, 32'h0000_0010);
    chk("tx_head", {24'b0, tx_tdata}, 32'h42);
    cpu(BASE + 32'hC0, 32'h1, 4'h1, r, n);

    rx_tvalid = 1'b1;
    for (int b = 16; b < 32; b++) begin
      rx_tdata = 8'(b);
      step();
    end
    rx_tdata = 8'h20;
    step();
    step();
    chk("rx_full_ready", {31'b0, rx_tready}, 32'h0);
    cpu(BASE, 32'h0, 4'h0, r, n);
    chk("rx_rd_0", r, 32'h8000_0010);
    rx_tvalid = 1'b0;
    for (int i = 1; i < 16; i++) begin
      cpu(BASE, 32'h0, 4'h0, r, n);
      chk("rx_rd", r, 32'h8000_0010 + i);
    end
    cpu(BASE, 32'h0, 4'h0, r, n);
    chk("rx_rd_20", r, 32'h8000_0020);
    cpu(BASE, 32'h0, 4'h0, r, n);
    chk("rx_rd_empty", r, 32'h0);

    for (int b = 8'h51; b < 8'h54; b++) begin
      rx_tvalid = 1'b1;
      rx_tdata  = 8'(b);
      step();
    end
    mem_valid = 1'b1;
    mem_addr  = BASE;
    mem_wstrb = 4'h0;
    rx_tdata  = 8'h54;
    step();
    rx_tvalid = 1'b0;
    chk("same_ready", {31'b0, mem_ready}, 32'h1);
    chk("same_rdata", mem_rdata, 32'h8000_0051);
    mem_valid = 1'b0;
    step();
    cpu(BASE + 32'h80, 32'h0, 4'h0, r, n);
    chk("same_level", r, 32'h0003_0000);
    for (int i = 0; i < 3; i++) begin
      cpu(BASE, 32'h0, 4'h0, r, n);
      chk("same_order", r, 32'h8000_0052 + i);
    end

    for (int i = 0; i < 5; i++) begin
      cpu(BASE, 32'h60 + i, 4'h2, r, n);
      rx_tvalid = 1'b1;
      rx_tdata  = 8'(8'h70 + i);
      step();
      rx_tvalid = 1'b0;
    end
    cpu(BASE + 32'h80, 32'h0, 4'h0, r, n);
    chk("level_5_5", r, 32'h0005_0005);
    mem_valid = 1'b1;
    mem_addr  = BASE + 32'hC0;
    mem_wdata = 32'h1;
    mem_wstrb = 4'h1;
    rx_tvalid = 1'b1;
    rx_tdata  = 8'hEE;
    step();
    rx_tvalid = 1'b0;
    mem_valid = 1'b0;
    mem_wstrb = '0;
    step();
    cpu(BASE + 32'h80, 32'h0, 4'h0, r, n);
    chk("level_flushed", r, 32'h0);
    chk("tvalid_flushed", {31'b0, tx_tvalid}, 32'h0);
    cpu(BASE + 32'h10, 32'h0, 4'h0, r, n);
    chk("other_off_rd", r, 32'h0);
    chk("other_off_lat", n, 1);

    rx_acc = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if (c == 2000) do_reset();
      tx_tready = ($urandom_range(0, 99) < (c < 2000 ? 25 : 75));
      if (!rx_tvalid || rx_acc) begin
        rx_tvalid = ($urandom_range(0, 2) != 0);
        rx_tdata  = 8'($urandom);
      end
      if (!mem_valid || mem_ready || mem_addr[31:8] != BASE[31:8]) begin
        k = $urandom_range(0, 19);
        mem_valid = (k < 18);
        mem_wdata = $urandom;
        mem_wstrb = $urandom_range(0, 1) ? 4'($urandom_range(1, 15)) : 4'h0;
        if (k < 8)       mem_addr = BASE;
        else if (k < 11) mem_addr = BASE + 32'h40;
        else if (k < 13) mem_addr = BASE + 32'h80;
        else if (k < 14) mem_addr = BASE + 32'hC0;
        else if (k < 17) mem_addr = BASE + 32'($urandom_range(0, 255));
        else             mem_addr = BASE ^ (32'h100 << $urandom_range(0, 23));
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
